// File: rtl/ysyx_22041211_exec_ctrl_if.sv
// Fetch / decode / execute handshake bundle between the core control FSM
// (master) and the fetch unit, decoder and execute unit (slave side).
interface ysyx_22041211_exec_ctrl_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                ifu_req_valid;
    logic [DATA_LEN-1:0] ifu_req_addr;
    logic                ifu_rsp_valid;
    logic [DATA_LEN-1:0] ifu_rsp_data;
    logic [DATA_LEN-1:0] inst;
    logic [2:0]          key;
    logic [DATA_LEN-1:0] imm;
    logic                exu_start;
    logic                exu_done;
    logic                wb_en;

    modport master (
        output ifu_req_valid, ifu_req_addr, inst, exu_start, wb_en,
        input  ifu_rsp_valid, ifu_rsp_data, key, imm, exu_done
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr, inst, exu_start, wb_en,
        output ifu_rsp_valid, ifu_rsp_data, key, imm, exu_done
    );
endinterface

// File: rtl/ysyx_22041211_exec_ctrl.sv
// Multi-cycle control FSM for the single-issue core: fetch, decode, execute,
// writeback and PC commit, with sticky halt (ebreak) and fault (bad opcode / fetch timeout).
module ysyx_22041211_exec_ctrl #(
    parameter int unsigned         DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned         TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22041211_exec_ctrl_if.master bus,
    output logic [DATA_LEN-1:0]       pc,
    output logic [31:0]               retired,
    output logic                      halt,
    output logic                      fault
);

    localparam logic [2:0] KEY_I   = 3'b000;
    localparam logic [2:0] KEY_N   = 3'b001;
    localparam logic [2:0] KEY_U   = 3'b010;
    localparam logic [2:0] KEY_R   = 3'b011;
    localparam logic [2:0] KEY_J   = 3'b101;
    localparam logic [2:0] KEY_BAD = 3'b111;

    localparam logic [DATA_LEN-1:0] INST_EBREAK = DATA_LEN'(32'h0010_0073);
    localparam logic [DATA_LEN-1:0] INST_ECALL  = DATA_LEN'(32'h0000_0073);
    localparam logic [DATA_LEN-1:0] PC_STEP     = DATA_LEN'(4);

    // Value the WAIT counter holds during the TIMEOUT-th cycle without a response.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        DEC_EXEC,
        DEC_ECALL,
        DEC_EBREAK,
        DEC_BAD
    } dec_e;

    state_e              state_q;
    state_e              state_d;
    dec_e                dec;
    logic [DATA_LEN-1:0] inst_q;
    logic [7:0]          wait_cnt;
    logic                wait_expired;
    logic                req_valid;
    logic                start;
    logic                wb;

    assign bus.ifu_req_valid = req_valid;
    assign bus.ifu_req_addr  = pc;
    assign bus.inst          = inst_q;
    assign bus.exu_start     = start;
    assign bus.wb_en         = wb;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // Classify the registered instruction; the invalid key code outranks the
    // system-word matches, and any other N-type word is treated as invalid.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dec = DEC_EXEC;
        if (bus.key == KEY_BAD) begin
            dec = DEC_BAD;
        end else if (inst_q == INST_EBREAK) begin
            dec = DEC_EBREAK;
        end else if (inst_q == INST_ECALL) begin
            dec = DEC_ECALL;
        end else if (bus.key == KEY_N) begin
            dec = DEC_BAD;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and strobes.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        start     = 1'b0;
        wb        = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                req_valid = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ifu_rsp_valid) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                case (dec)
                    DEC_EXEC: begin
                        start   = 1'b1;
                        state_d = S_EXEC;
                    end
                    DEC_ECALL: state_d = S_FETCH;
                    default:   state_d = S_HALT;
                endcase
            end
            S_EXEC: begin
                if (bus.exu_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb      = bus.key inside {KEY_I, KEY_U, KEY_R, KEY_J};
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Architectural state: PC, instruction register, retire count, WAIT counter and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inst_q   <= '0;
            retired  <= '0;
            wait_cnt <= '0;
            halt     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (bus.ifu_rsp_valid) begin
                        inst_q <= bus.ifu_rsp_data;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_expired) begin
                            fault <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    case (dec)
                        DEC_BAD: begin
                            fault <= 1'b1;
                        end
                        DEC_EBREAK: begin
                            halt    <= 1'b1;
                            retired <= retired + 32'd1;
                        end
                        DEC_ECALL: begin
                            pc      <= pc + PC_STEP;
                            retired <= retired + 32'd1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_WB: begin
                    // J-type commits a PC-relative target; everything else falls through.
                    pc      <= (bus.key == KEY_J) ? pc + bus.imm : pc + PC_STEP;
                    retired <= retired + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_exec_ctrl.sv
// Self-checking bench for ysyx_22041211_exec_ctrl: directed scenarios plus a
// randomized instruction stream checked against an instruction-level PC/retire model.
module tb_ysyx_22041211_exec_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] W_EBREAK = 32'h0010_0073;
  localparam logic [31:0] W_ECALL  = 32'h0000_0073;
  localparam logic [2:0]  K_I = 3'b000, K_N = 3'b001, K_U = 3'b010, K_R = 3'b011,
                          K_S = 3'b100, K_J = 3'b101, K_BAD = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halt;
  logic        fault;

  ysyx_22041211_exec_ctrl_if #(.DATA_LEN(32)) bus ();

  ysyx_22041211_exec_ctrl #(
    .DATA_LEN(32),
    .RESET_PC(RESET_PC),
    .TIMEOUT (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .retired(retired),
    .halt   (halt),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state.
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Architectural effect of one completed non-halting instruction.
  task automatic model_commit(input logic [2:0] k, input logic [31:0] im);
    m_pc  = m_pc + ((k == K_J) ? im : 32'd4);
    m_ret = m_ret + 32'd1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.key           = K_I;
    bus.imm           = '0;
    bus.exu_done      = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_pc  = RESET_PC;
    m_ret = 32'd0;
  endtask

  // Expects a fetch request on the very next negedge (no bubble); bounded search.
  task automatic wait_fetch(input string tag);
    int waited = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      waited++;
      seen = bus.ifu_req_valid;
    end
    check_b($sformatf("%s/fetch_seen", tag), seen, 1'b1);
    check($sformatf("%s/no_bubble", tag), 32'(waited), 32'd1);
    check($sformatf("%s/req_addr", tag), bus.ifu_req_addr, m_pc);
    check($sformatf("%s/pc", tag), pc, m_pc);
    check($sformatf("%s/retired", tag), retired, m_ret);
  endtask

  // From the FETCH negedge: withhold the response for d WAIT cycles, then deliver it.
  // Returns at the DECODE negedge.
  task automatic respond(input logic [31:0] word, input logic [2:0] k,
                         input logic [31:0] im, input int d);
    repeat (d) begin
      @(negedge clk);
      bus.exu_done = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.exu_done      = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_data  = word;
    bus.key           = k;
    bus.imm           = im;
    @(negedge clk);
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = $urandom;
  endtask

  // From the DECODE negedge of an executing instruction through its WB negedge.
  task automatic exec_phase(input string tag, input logic [31:0] word, input logic [2:0] k,
                            input logic [31:0] im, input int ed, input bit wrap);
    int extra_starts = 0;
    check_b($sformatf("%s/exu_start", tag), bus.exu_start, 1'b1);
    for (int i = 0; i <= ed; i++) begin
      @(negedge clk);
      if (bus.exu_start) extra_starts++;
      if (bus.wb_en) extra_starts++;
      if (wrap && i == 0) begin
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        m_ret = 32'hFFFF_FFFF;
      end
      bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
      bus.ifu_rsp_data  = $urandom;
      bus.exu_done      = (i == ed);
    end
    @(negedge clk);
    bus.exu_done      = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    if (bus.exu_start) extra_starts++;
    check($sformatf("%s/single_start", tag), 32'(extra_starts), 32'd0);
    check_b($sformatf("%s/wb_en", tag), bus.wb_en, (k != K_S));
    check($sformatf("%s/inst_held", tag), bus.inst, word);
    model_commit(k, im);
  endtask

  logic [2:0] keys [5] = '{K_I, K_U, K_R, K_S, K_J};

  initial begin
    // Reset values while rst is held.
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.key           = K_I;
    bus.imm           = '0;
    bus.exu_done      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/pc", pc, RESET_PC);
    check("rst/req_addr", bus.ifu_req_addr, RESET_PC);
    check("rst/inst", bus.inst, 32'd0);
    check("rst/retired", retired, 32'd0);
    check_b("rst/req_valid", bus.ifu_req_valid, 1'b0);
    check_b("rst/exu_start", bus.exu_start, 1'b0);
    check_b("rst/wb_en", bus.wb_en, 1'b0);
    check_b("rst/halt", halt, 1'b0);
    check_b("rst/fault", fault, 1'b0);
    rst   = 1'b0;
    m_pc  = RESET_PC;
    m_ret = 32'd0;

    // addi x1, x0, 1 at minimum latency.
    wait_fetch("addi");
    respond(32'h0010_0093, K_I, 32'd1, 0);
    exec_phase("addi", 32'h0010_0093, K_I, 32'd1, 0, 1'b0);
    wait_fetch("post_addi");
    check("post_addi/pc_abs", pc, 32'h8000_0004);

    // jal +8 from reset PC, then a store, then an ecall.
    do_reset();
    wait_fetch("jal");
    respond(32'h0080_006F, K_J, 32'd8, 1);
    exec_phase("jal", 32'h0080_006F, K_J, 32'd8, 2, 1'b0);
    wait_fetch("post_jal");
    check("post_jal/pc_abs", pc, 32'h8000_0008);
    respond(32'h0011_2023, K_S, 32'd0, 0);
    exec_phase("sw", 32'h0011_2023, K_S, 32'd0, 0, 1'b0);
    wait_fetch("post_sw");
    respond(W_ECALL, K_N, 32'd0, 2);
    check_b("ecall/no_start", bus.exu_start, 1'b0);
    model_commit(K_N, 32'd0);
    wait_fetch("post_ecall");

    // Randomized instruction stream; one instruction has retired forced to wrap.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] w;
      logic [31:0] im;
      logic [2:0]  k;
      int          rd;
      int          ed;
      im = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        w = W_ECALL;
        k = K_N;
      end else begin
        k = keys[$urandom_range(0, 4)];
        w = $urandom;
        if (w[6:0] == 7'h73) w[6:0] = 7'h13;
      end
      rd = $urandom_range(0, 3);
      ed = $urandom_range(0, 3);
      respond(w, k, im, rd);
      if (k == K_N) begin
        check_b("rand/ecall_no_start", bus.exu_start, 1'b0);
        model_commit(K_N, im);
      end else begin
        exec_phase("rand", w, k, im, ed, n == 10);
      end
      wait_fetch("rand");
    end

    // ebreak halts, counts as retired, and freezes everything for good.
    begin
      int reqs = 0;
      int strobes = 0;
      respond(W_EBREAK, K_N, 32'd0, 0);
      check_b("ebreak/no_start", bus.exu_start, 1'b0);
      @(negedge clk);
      m_ret = m_ret + 32'd1;
      check_b("ebreak/halt", halt, 1'b1);
      check_b("ebreak/fault", fault, 1'b0);
      check("ebreak/retired", retired, m_ret);
      repeat (20) begin
        @(negedge clk);
        if (bus.ifu_req_valid) reqs++;
        if (bus.exu_start || bus.wb_en) strobes++;
        bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
        bus.ifu_rsp_data  = $urandom;
        bus.exu_done      = 1'($urandom_range(0, 1));
      end
      check("ebreak/no_fetch", 32'(reqs), 32'd0);
      check("ebreak/no_strobes", 32'(strobes), 32'd0);
      check("ebreak/pc_frozen", pc, m_pc);
      check("ebreak/ret_frozen", retired, m_ret);
      check("ebreak/inst_frozen", bus.inst, W_EBREAK);
      check_b("ebreak/halt_sticky", halt, 1'b1);
    end

    // Invalid key code faults without halting.
    do_reset();
    wait_fetch("bad");
    respond(32'hFFFF_FFFF, K_BAD, 32'd0, 0);
    check_b("bad/no_start", bus.exu_start, 1'b0);
    @(negedge clk);
    check_b("bad/fault", fault, 1'b1);
    check_b("bad/halt", halt, 1'b0);
    check("bad/retired", retired, 32'd0);

    // Non-ecall/ebreak N-type word (mret) is invalid.
    do_reset();
    wait_fetch("mret");
    respond(32'h3020_0073, K_N, 32'd0, 0);
    check_b("mret/no_start", bus.exu_start, 1'b0);
    @(negedge clk);
    check_b("mret/fault", fault, 1'b1);
    check_b("mret/halt", halt, 1'b0);

    // Fetch timeout after exactly 4 WAIT cycles; a late response is ignored.
    begin
      int reqs = 0;
      do_reset();
      wait_fetch("tmo");
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        check_b($sformatf("tmo/no_fault_wait%0d", i), fault, 1'b0);
      end
      @(negedge clk);
      check_b("tmo/fault", fault, 1'b1);
      check_b("tmo/halt", halt, 1'b0);
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_data  = 32'hDEAD_BEEF;
      repeat (3) begin
        @(negedge clk);
        if (bus.ifu_req_valid) reqs++;
      end
      bus.ifu_rsp_valid = 1'b0;
      check("tmo/inst_unchanged", bus.inst, 32'd0);
      check("tmo/no_refetch", 32'(reqs), 32'd0);
    end

    // Response in the last allowed WAIT cycle still succeeds.
    do_reset();
    wait_fetch("late");
    respond(32'h0010_0093, K_I, 32'd1, 3);
    check_b("late/no_fault", fault, 1'b0);
    exec_phase("late", 32'h0010_0093, K_I, 32'd1, 1, 1'b0);
    wait_fetch("post_late");

    // Asynchronous reset in the middle of EXEC.
    respond(32'h0020_0113, K_I, 32'd2, 0);
    check_b("arst/start", bus.exu_start, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst/pc", pc, RESET_PC);
    check("arst/retired", retired, 32'd0);
    check("arst/inst", bus.inst, 32'd0);
    check_b("arst/req_valid", bus.ifu_req_valid, 1'b0);
    check_b("arst/exu_start", bus.exu_start, 1'b0);
    check_b("arst/wb_en", bus.wb_en, 1'b0);
    check_b("arst/halt", halt, 1'b0);
    check_b("arst/fault", fault, 1'b0);
    bus.exu_done = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_b("arst/idle_no_req", bus.ifu_req_valid, 1'b0);
    @(negedge clk);
    check_b("arst/first_req", bus.ifu_req_valid, 1'b1);
    check("arst/first_addr", bus.ifu_req_addr, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_exec_ctrl.md
# ysyx_22041211_exec_ctrl

Multi-cycle control FSM that sequences the single-issue core around the instruction decoder. It issues instruction fetches, holds the fetched word in an instruction register that drives the decoder, and starts the execute unit. It then commits writeback and the next PC, and halts the core on `ebreak`, an undecodable opcode or a fetch timeout.

## Interface
- `DATA_LEN`, 32, instruction/address/data width
- `RESET_PC`, 32'h80000000, PC value loaded on reset
- `TIMEOUT`, 255, maximum cycles spent in WAIT before a fetch fault (1..255; counter is 8 bits)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous and active-high
- `ifu_req_valid` out 1: fetch request strobe
- `ifu_req_addr` out DATA_LEN: fetch address (= `pc`)
- `ifu_rsp_valid` in 1: fetch data valid
- `ifu_rsp_data` in DATA_LEN: fetched instruction word
- `inst` out DATA_LEN: instruction register, drives decoder `inst`
- `key` in 3: decoder type code: 000 I, 001 N, 010 U, 011 R, 100 S, 101 J, 111 invalid
- `imm` in DATA_LEN: decoder immediate
- `exu_start` out 1: one-cycle execute start pulse
- `exu_done` in 1: execute complete
- `wb_en` out 1: register-file write enable, one-cycle pulse
- `pc` out DATA_LEN: current PC
- `retired` out 32: retired-instruction counter
- `halt` out 1: sticky, core stopped by `ebreak`
- `fault` out 1: sticky, stopped by invalid opcode or fetch timeout

## Operation
- Reset values: state IDLE, `pc`=RESET_PC, `inst`=0, `retired`=0, WAIT counter=0; `ifu_req_valid`, `exu_start`, `wb_en`, `halt` and `fault` are 0. `ifu_req_addr` follows `pc`.
- IDLE: go to FETCH unconditionally.
- FETCH: `ifu_req_valid`=1 for exactly one cycle. Clear the WAIT counter. Go to WAIT.
- WAIT:
  - If `ifu_rsp_valid`=1: `inst`<=`ifu_rsp_data`, go to DECODE.
  - Otherwise increment the counter. Once the counter reaches TIMEOUT without a response: `fault`<=1, go to HALT.
- DECODE: one cycle, using decoder outputs for the registered `inst`.
  - `key`==111: `fault`<=1, go to HALT.
  - `inst`==32'h00100073 (ebreak): `halt`<=1, `retired`+=1, go to HALT.
  - `inst`==32'h00000073 (ecall): no execute. `pc`<=`pc`+4, `retired`+=1, go to FETCH.
  - Any other N-type word: treat as invalid; `fault`<=1, go to HALT.
  - Otherwise: assert `exu_start` for this one cycle and go to EXEC.
- EXEC: wait for `exu_done`=1, then go to WB. No timeout.
- WB: one cycle.
  - `wb_en`=1 for `key` in {000, 010, 011, 101}; 0 for S (100).
  - Next PC: `pc`+`imm` for J (101), `pc`+4 for all others.
  - `retired`+=1. Go to FETCH.
- HALT: terminal. All strobes are 0; `pc`, `inst` and `retired` are frozen. Only `rst` leaves this state.
- Arithmetic: PC and `retired` wrap modulo 2^32 with no flag. `imm` is used as already sign-extended by the decoder.
- `key` and `imm` are sampled only in DECODE and WB. The instruction register is stable from DECODE through WB, so the decoder output is stable there.

## Timing
- Minimum instruction latency is 5 cycles: FETCH, WAIT (response in the first WAIT cycle), DECODE, EXEC (`exu_done` in the same cycle as entry), WB.
- Back-to-back: FETCH follows WB on the next cycle, so there is no idle bubble.
- Handshake filtering:
  - `ifu_rsp_valid` is honoured only in WAIT and ignored in all other states; stale responses are dropped.
  - `exu_done` is honoured only in EXEC.
  - Outside WAIT, the WAIT counter holds.
- Strobe placement:
  - `exu_start` is high only in the DECODE cycle that transitions to EXEC.
  - `wb_en` is high only in WB.
  - Neither strobe is ever high for two consecutive cycles.
- `halt` and `fault` assert on the clock edge leaving DECODE or WAIT, and stay asserted until reset.
- Reset asserted mid-operation clears all state immediately, asynchronously. An in-flight fetch or execute is abandoned. The first FETCH occurs 2 cycles after `rst` deasserts (IDLE, then FETCH).

## Test plan
- Reset, then respond to the first fetch with 32'h00100093 (addi x1, x0, 1):
  - `ifu_req_addr`=32'h80000000.
  - `exu_start` pulses once, then `wb_en` pulses once.
  - After WB: `pc`=32'h80000004, `retired`=1.
- Jal: fetch 32'h0080006F with `imm`=8, `key`=101 → `wb_en`=1, `pc` goes 80000000→80000008.
- Store: fetch 32'h00112023 with `key`=100 → `exu_start` pulses, `wb_en` stays 0, `pc`+=4.
- Ebreak, then invalid:
  - Fetch 32'h00100073 → `halt`=1, `retired`+1, no further `ifu_req_valid` over 20 cycles.
  - After reset, fetch 32'hFFFFFFFF with `key`=111 → `fault`=1, `halt`=0.
- Timeout with TIMEOUT=4: withhold `ifu_rsp_valid` → `fault`=1 after 4 WAIT cycles. A late `ifu_rsp_valid` then leaves `inst` unchanged.
- Asynchronous reset during EXEC: assert `rst` mid-cycle → outputs return to reset values before the next edge; the first `ifu_req_valid` follows 2 cycles after deassertion. Also check that `retired` wraps 32'hFFFFFFFF→0.
